// File: rtl/memmap_pkg.sv
// Shared memory-map constants, FSM state encoding and region types for the
// CPU/DMA memory arbiter.
package memmap_pkg;

    localparam logic [15:0] IO_ADDR        = 16'h0000;
    localparam logic [15:0] VGA_BASE_DEF   = 16'h1000;
    localparam logic [15:0] SDRAM_BASE_DEF = 16'h4c00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_IO,
        RGN_UNMAPPED,
        RGN_VGA,
        RGN_SDRAM
    } region_t;

    // Slave-relative address; wraps modulo 2^16 by construction.
    function automatic logic [15:0] rebase(input logic [15:0] addr, input logic [15:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/mem_decode.sv
// Combinational region decode of a 16-bit bus address into IO, unmapped,
// VGA framebuffer or SDRAM.
module mem_decode
    import memmap_pkg::*;
#(
    parameter logic [15:0] VGA_BASE   = VGA_BASE_DEF,
    parameter logic [15:0] SDRAM_BASE = SDRAM_BASE_DEF
) (
    input  logic [15:0] addr,
    output region_t     region
);

    always_comb begin
        region = RGN_UNMAPPED;
        if (addr == IO_ADDR) begin
            region = RGN_IO;
        end else if (addr >= SDRAM_BASE) begin
            region = RGN_SDRAM;
        end else if (addr >= VGA_BASE) begin
            region = RGN_VGA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU m0, DMA m1) memory arbiter in front of IO, VGA and SDRAM.
// Define MEMARB_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module mem_arbiter
    import memmap_pkg::*;
#(
    parameter logic [15:0] VGA_BASE   = VGA_BASE_DEF,
    parameter logic [15:0] SDRAM_BASE = SDRAM_BASE_DEF
) (
    input  logic        clki,
    input  logic        rst,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m0_wdata,
    input  logic [15:0] m1_wdata,
    input  logic        m0_rd,
    input  logic        m1_rd,
    input  logic        m0_wr,
    input  logic        m1_wr,
    output logic [15:0] m0_rdata,
    output logic [15:0] m1_rdata,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic        m0_busy,
    output logic        m1_busy,
    output logic [23:0] sd_addr,
    output logic [15:0] sd_wdata,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_busy,
    input  logic        sd_ready,
    input  logic [15:0] sd_rdata,
    output logic [15:0] vga_addr,
    output logic [15:0] vga_wdata,
    output logic        vga_wr,
    input  logic [15:0] io_rdata
);

    state_t      state_q, state_d;
    region_t     region;
    logic        req0, req1, any_req;
    logic        pick_m1;
    logic        grant_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic [15:0] rdata_q;

    // Completion is keyed on sd_ready alone; sd_busy is status only.
    logic unused_sd_busy;
    assign unused_sd_busy = sd_busy;

    assign req0    = m0_rd | m0_wr;
    assign req1    = m1_rd | m1_wr;
    assign any_req = req0 | req1;

`ifdef MEMARB_RR_EN
    // last_m1_q resets high so m0 holds priority first after reset.
    logic last_m1_q;
    assign pick_m1 = req1 & (~req0 | ~last_m1_q);

    always_ff @(posedge clki) begin
        if (rst) begin
            last_m1_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_m1_q <= pick_m1;
        end
    end
`else
    assign pick_m1 = req1 & ~req0;
`endif

    mem_decode #(
        .VGA_BASE   (VGA_BASE),
        .SDRAM_BASE (SDRAM_BASE)
    ) u_decode (
        .addr   (addr_q),
        .region (region)
    );

    always_ff @(posedge clki) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= pick_m1;
            end
            if (state_q == ISSUE && region != RGN_SDRAM) begin
                rdata_q <= (region == RGN_IO && !wr_q) ? io_rdata : 16'h0000;
            end else if (state_q == WAIT && sd_ready) begin
                rdata_q <= sd_rdata;
            end
        end
    end

    // Request payload; a simultaneous rd+wr is recorded as a write.
    always_ff @(posedge clki) begin
        if (state_q == IDLE && any_req) begin
            addr_q  <= pick_m1 ? m1_addr  : m0_addr;
            wdata_q <= pick_m1 ? m1_wdata : m0_wdata;
            wr_q    <= pick_m1 ? m1_wr    : m0_wr;
        end
    end

    always_comb begin
        state_d  = state_q;
        sd_rd    = 1'b0;
        sd_wr    = 1'b0;
        vga_wr   = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (region == RGN_SDRAM) begin
                    sd_wr   = wr_q;
                    sd_rd   = ~wr_q;
                    state_d = WAIT;
                end else begin
                    vga_wr  = (region == RGN_VGA) && wr_q;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (sd_ready) state_d = DONE;
            end
            DONE: begin
                m0_ready = ~grant_q;
                m1_ready = grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave buses come straight from the captured request, so they stay
    // stable for the whole ISSUE..WAIT window.
    assign sd_addr   = {8'h00, rebase(addr_q, SDRAM_BASE)};
    assign sd_wdata  = wdata_q;
    assign vga_addr  = rebase(addr_q, VGA_BASE);
    assign vga_wdata = wdata_q;

    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
    assign m0_busy  = req0 | (state_q != IDLE && !grant_q);
    assign m1_busy  = req1 | (state_q != IDLE && grant_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (fixed-priority or round-robin build).
module tb_mem_arbiter;

    logic        clki = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_rd = 0, m1_rd = 0, m0_wr = 0, m1_wr = 0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_busy, m1_busy;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata;
    logic        sd_rd, sd_wr;
    logic        sd_busy = 1'b0, sd_ready = 1'b0;
    logic [15:0] sd_rdata = '0;
    logic [15:0] vga_addr, vga_wdata;
    logic        vga_wr;
    logic [15:0] io_rdata = 16'h00A5;

    int checks = 0;
    int errors = 0;

    int n_sd_rd, n_sd_wr, n_vga_wr, n_rdy0, n_rdy1;
    logic [23:0] cap_sd_addr;
    logic [15:0] cap_sd_wdata, cap_vga_addr, cap_vga_wdata;

    mem_arbiter dut (
        .clki(clki), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rd(m0_rd), .m1_rd(m1_rd), .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_ready(m0_ready), .m1_ready(m1_ready),
        .m0_busy(m0_busy), .m1_busy(m1_busy),
        .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_busy(sd_busy), .sd_ready(sd_ready), .sd_rdata(sd_rdata),
        .vga_addr(vga_addr), .vga_wdata(vga_wdata), .vga_wr(vga_wr),
        .io_rdata(io_rdata)
    );

    always #5 clki = ~clki;

    always @(negedge clki) begin
        if (sd_rd) begin n_sd_rd++; cap_sd_addr = sd_addr; end
        if (sd_wr) begin n_sd_wr++; cap_sd_addr = sd_addr; cap_sd_wdata = sd_wdata; end
        if (vga_wr) begin n_vga_wr++; cap_vga_addr = vga_addr; cap_vga_wdata = vga_wdata; end
        if (m0_ready) n_rdy0++;
        if (m1_ready) n_rdy1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        n_sd_rd = 0; n_sd_wr = 0; n_vga_wr = 0; n_rdy0 = 0; n_rdy1 = 0;
        cap_sd_addr = '0; cap_sd_wdata = '0; cap_vga_addr = '0; cap_vga_wdata = '0;
    endtask

    task automatic drop_reqs();
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    endtask

    // Latency counts edges from request to the edge on which ready is captured.
    task automatic run_txn(input int m, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int waitn, input logic [15:0] sd_val,
                           output int lat, output logic [15:0] rdata);
        @(posedge clki); #1;
        clear_counts();
        if (m == 0) begin m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; end
        else begin m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; end
        lat = -1;
        rdata = 16'hxxxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clki);
            sd_ready = (waitn > 0 && c == 2 + waitn);
            sd_rdata = sd_val;
            if (c == 2) begin
                checks++;
                if ((m == 0 ? {m0_busy, m1_busy} : {m1_busy, m0_busy}) !== 2'b10) begin
                    errors++;
                    $display("FAIL busy_m%0d got m0=%b m1=%b", m, m0_busy, m1_busy);
                end
            end
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
                lat = c;
                rdata = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        @(posedge clki); #1;
        drop_reqs();
        sd_ready = 1'b0;
        @(negedge clki);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clki);
        @(negedge clki);
        checks++;
        if ({m0_ready, m1_ready, m0_busy, m1_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rdy_busy got %b exp 0000", {m0_ready, m1_ready, m0_busy, m1_busy});
        end
        checks++;
        if ({sd_rd, sd_wr, vga_wr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 000", {sd_rd, sd_wr, vga_wr});
        end
        checks++;
        if (m0_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0000", m0_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_io_read();
        int lat; logic [15:0] rd;
        io_rdata = 16'h00A5;
        run_txn(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, lat, rd);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL io_lat got %0d exp 3", lat); end
        checks++;
        if (rd !== 16'h00A5) begin errors++; $display("FAIL io_rdata got %h exp 00a5", rd); end
        checks++;
        if (n_sd_rd + n_sd_wr + n_vga_wr !== 0) begin
            errors++; $display("FAIL io_strobes got %0d exp 0", n_sd_rd + n_sd_wr + n_vga_wr);
        end
        checks++;
        if (n_rdy0 !== 1) begin errors++; $display("FAIL io_ready_width got %0d exp 1", n_rdy0); end
    endtask

    task automatic test_vga_write();
        int lat; logic [15:0] rd;
        run_txn(0, 0, 1, 16'h1010, 16'h1234, 0, 16'h0000, lat, rd);
        checks++;
        if (n_vga_wr !== 1 || n_sd_rd + n_sd_wr !== 0) begin
            errors++; $display("FAIL vga_strobes got vga=%0d sd=%0d exp 1/0", n_vga_wr, n_sd_rd + n_sd_wr);
        end
        checks++;
        if (cap_vga_addr !== 16'h0010) begin errors++; $display("FAIL vga_addr got %h exp 0010", cap_vga_addr); end
        checks++;
        if (cap_vga_wdata !== 16'h1234) begin errors++; $display("FAIL vga_wdata got %h exp 1234", cap_vga_wdata); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL vga_lat got %0d exp 3", lat); end
    endtask

    task automatic test_sdram_read();
        int lat; logic [15:0] rd;
        run_txn(1, 1, 0, 16'h4c05, 16'h0000, 4, 16'hBEEF, lat, rd);
        checks++;
        if (cap_sd_addr !== 24'h000005) begin errors++; $display("FAIL sd_addr got %h exp 000005", cap_sd_addr); end
        checks++;
        if (n_sd_rd !== 1 || n_sd_wr !== 0) begin
            errors++; $display("FAIL sd_rd_strobe got rd=%0d wr=%0d exp 1/0", n_sd_rd, n_sd_wr);
        end
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL sd_lat got %0d exp 7", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL sd_rdata got %h exp beef", rd); end
        checks++;
        if (n_rdy1 !== 1 || n_rdy0 !== 0) begin
            errors++; $display("FAIL sd_ready_pulse got m0=%0d m1=%0d exp 0/1", n_rdy0, n_rdy1);
        end
    endtask

    task automatic test_vga_read();
        int lat; logic [15:0] rd;
        run_txn(1, 1, 0, 16'h1000, 16'h0000, 0, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL vga_read_rdata got %h exp 0000", rd); end
        checks++;
        if (n_sd_rd + n_sd_wr + n_vga_wr !== 0) begin
            errors++; $display("FAIL vga_read_strobes got %0d exp 0", n_sd_rd + n_sd_wr + n_vga_wr);
        end
    endtask

    task automatic test_sdram_write_rdwr();
        int lat; logic [15:0] rd;
        run_txn(0, 1, 1, 16'h4c20, 16'hC0DE, 1, 16'h1111, lat, rd);
        checks++;
        if (n_sd_wr !== 1 || n_sd_rd !== 0) begin
            errors++; $display("FAIL sdw_strobe got wr=%0d rd=%0d exp 1/0", n_sd_wr, n_sd_rd);
        end
        checks++;
        if (cap_sd_addr !== 24'h000020 || cap_sd_wdata !== 16'hC0DE) begin
            errors++; $display("FAIL sdw_bus got %h/%h exp 000020/c0de", cap_sd_addr, cap_sd_wdata);
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL sdw_lat got %0d exp 4", lat); end
    endtask

    task automatic test_unmapped_and_io_write();
        int lat; logic [15:0] rd;
        run_txn(0, 1, 0, 16'h0800, 16'h0000, 0, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h0000 || lat !== 3) begin
            errors++; $display("FAIL unmapped_read got rdata=%h lat=%0d exp 0000/3", rd, lat);
        end
        checks++;
        if (n_sd_rd + n_sd_wr + n_vga_wr !== 0) begin
            errors++; $display("FAIL unmapped_strobes got %0d exp 0", n_sd_rd + n_sd_wr + n_vga_wr);
        end
        run_txn(1, 0, 1, 16'h0000, 16'h7777, 0, 16'h0000, lat, rd);
        checks++;
        if (lat !== 3 || n_sd_rd + n_sd_wr + n_vga_wr !== 0) begin
            errors++; $display("FAIL io_write got lat=%0d strobes=%0d exp 3/0", lat, n_sd_rd + n_sd_wr + n_vga_wr);
        end
    endtask

    task automatic test_arbitration();
        int order[3];
        int expo[3];
        int n;
`ifdef MEMARB_RR_EN
        expo = '{0, 1, 0};
`else
        expo = '{0, 0, 0};
`endif
        order = '{-1, -1, -1};
        test_reset();
        @(posedge clki); #1;
        m0_addr = 16'h0000; m1_addr = 16'h0000;
        m0_rd = 1; m1_rd = 1;
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clki);
            if (m0_ready) begin order[n] = 0; n++; end
            else if (m1_ready) begin order[n] = 1; n++; end
        end
        @(posedge clki); #1;
        drop_reqs();
        @(negedge clki);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (order[i] !== expo[i]) begin
                errors++; $display("FAIL arb_order[%0d] got m%0d exp m%0d", i, order[i], expo[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [15:0] rd;
        @(posedge clki); #1;
        clear_counts();
        m1_addr = 16'h4c10; m1_rd = 1;
        repeat (3) @(negedge clki);
        rst = 1'b1;
        m1_rd = 0;
        @(negedge clki);
        checks++;
        if ({m1_ready, m1_busy, sd_rd} !== 3'b000) begin
            errors++; $display("FAIL rstwait_ctl got %b exp 000", {m1_ready, m1_busy, sd_rd});
        end
        checks++;
        if (m1_rdata !== 16'h0000) begin errors++; $display("FAIL rstwait_rdata got %h exp 0000", m1_rdata); end
        rst = 1'b0;
        sd_ready = 1'b1; sd_rdata = 16'hDEAD;
        @(negedge clki);
        sd_ready = 1'b0;
        repeat (3) @(negedge clki);
        checks++;
        if (n_rdy0 + n_rdy1 !== 0) begin errors++; $display("FAIL rstwait_noready got %0d exp 0", n_rdy0 + n_rdy1); end
        run_txn(1, 1, 0, 16'h4c10, 16'h0000, 2, 16'h5A5A, lat, rd);
        checks++;
        if (lat !== 5 || rd !== 16'h5A5A) begin
            errors++; $display("FAIL rstwait_fresh got lat=%0d rdata=%h exp 5/5a5a", lat, rd);
        end
        checks++;
        if (cap_sd_addr !== 24'h000010) begin errors++; $display("FAIL rstwait_addr got %h exp 000010", cap_sd_addr); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_io_read();
        test_vga_write();
        test_sdram_read();
        test_vga_read();
        test_sdram_write_rdwr();
        test_unmapped_and_io_write();
        test_arbitration();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
